// File: rtl/barrier_sync_unit_pkg.sv
// barrier_sync_unit_pkg
//   Shared definitions for the barrier synchronizer: per-channel state
//   encoding, default widths and a helper for the barrier-id width.
package barrier_sync_unit_pkg;

  typedef enum logic {
    BAR_IDLE  = 1'b0,
    BAR_ARMED = 1'b1
  } bar_state_e;

  localparam int unsigned DEF_NUM_PE  = 16;
  localparam int unsigned DEF_NUM_BAR = 4;
  localparam int unsigned DEF_GEN_W   = 4;
  localparam int unsigned DEF_TO_W    = 16;

  // Barrier-id width: clog2 of the channel count, never below one bit.
  function automatic int unsigned bid_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/barrier_sync_unit_channel.sv
// barrier_channel
//   One barrier channel: IDLE/ARMED FSM, latched configuration, per-PE
//   arrival bits, timeout timer, generation counter and sticky errors.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_accept      configuration handshake for this channel (only while IDLE)
//   cfg_mask/_persistent/_timeout  configuration payload
//   arrive          lanes arriving for this channel this cycle
//   err_clr         clears sticky error flags
//   idle            channel is IDLE
//   release_vec     registered one-cycle release pulse (participant mask)
//   gen             completed-generation count
//   err_timeout     sticky timeout flag
//   err_stray       sticky stray-arrival flag
module barrier_channel
  import barrier_sync_unit_pkg::*;
#(
  parameter int unsigned NUM_PE = DEF_NUM_PE,
  parameter int unsigned GEN_W  = DEF_GEN_W,
  parameter int unsigned TO_W   = DEF_TO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_accept,
  input  logic [NUM_PE-1:0] cfg_mask,
  input  logic              cfg_persistent,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic [NUM_PE-1:0] arrive,
  input  logic              err_clr,
  output logic              idle,
  output logic [NUM_PE-1:0] release_vec,
  output logic [GEN_W-1:0]  gen,
  output logic              err_timeout,
  output logic              err_stray
);

  bar_state_e        state_q, state_d;
  logic [NUM_PE-1:0] mask_q, mask_d;
  logic              pers_q, pers_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [NUM_PE-1:0] arrived_q, arrived_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [NUM_PE-1:0] rel_q, rel_d;
  logic              err_to_q, err_to_d;
  logic              err_st_q, err_st_d;

  logic [NUM_PE-1:0] valid_arr;
  logic [TO_W-1:0]   timer_inc;
  logic              stray;
  logic              complete;
  logic              expire;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pers_d    = pers_q;
    tmo_d     = tmo_q;
    arrived_d = arrived_q;
    timer_d   = timer_q;
    gen_d     = gen_q;
    rel_d     = '0;
    valid_arr = '0;
    stray     = 1'b0;
    complete  = 1'b0;
    expire    = 1'b0;
    timer_inc = timer_q + TO_W'(1);

    case (state_q)
      BAR_IDLE: begin
        // Any arrival while idle is stray, including the accept cycle.
        stray = |arrive;
        if (cfg_accept && (cfg_mask != '0)) begin
          mask_d    = cfg_mask;
          pers_d    = cfg_persistent;
          tmo_d     = cfg_timeout;
          arrived_d = '0;
          timer_d   = '0;
          state_d   = BAR_ARMED;
        end
      end
      BAR_ARMED: begin
        valid_arr = arrive & mask_q;
        stray     = |(arrive & ~mask_q);
        complete  = ((arrived_q | valid_arr) == mask_q);
        // Fires on the cycle in which the timer would reach the limit.
        expire    = (tmo_q != '0) && (timer_inc == tmo_q);
        if (complete) begin
          rel_d     = mask_q;
          gen_d     = gen_q + GEN_W'(1);
          arrived_d = '0;
          timer_d   = '0;
          state_d   = pers_q ? BAR_ARMED : BAR_IDLE;
        end else if (expire) begin
          arrived_d = '0;
          timer_d   = '0;
          state_d   = BAR_IDLE;
        end else begin
          arrived_d = arrived_q | valid_arr;
          if (tmo_q != '0) begin
            timer_d = timer_inc;
          end
        end
      end
      default: state_d = BAR_IDLE;
    endcase

    // A new error in the clear cycle keeps the flag set.
    err_to_d = (err_to_q & ~err_clr) | (expire & ~complete);
    err_st_d = (err_st_q & ~err_clr) | stray;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BAR_IDLE;
      mask_q    <= '0;
      pers_q    <= 1'b0;
      tmo_q     <= '0;
      arrived_q <= '0;
      timer_q   <= '0;
      gen_q     <= '0;
      rel_q     <= '0;
      err_to_q  <= 1'b0;
      err_st_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pers_q    <= pers_d;
      tmo_q     <= tmo_d;
      arrived_q <= arrived_d;
      timer_q   <= timer_d;
      gen_q     <= gen_d;
      rel_q     <= rel_d;
      err_to_q  <= err_to_d;
      err_st_q  <= err_st_d;
    end
  end

  assign idle        = (state_q == BAR_IDLE);
  assign release_vec = rel_q;
  assign gen         = gen_q;
  assign err_timeout = err_to_q;
  assign err_stray   = err_st_q;

endmodule

// File: rtl/barrier_sync_unit.sv
// barrier_sync_unit
//   Multi-channel barrier synchronizer for the PE array.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cfg_valid/ready  configuration handshake; ready = target channel IDLE
//   cfg_bar_id, cfg_mask, cfg_persistent, cfg_timeout  configuration payload
//   pe_arrive        per-PE arrival pulse
//   pe_bar_id        per-PE barrier id (BID_W bits per lane)
//   pe_release       registered release pulse, OR of all channels
//   bar_active       per-channel ARMED status
//   bar_gen          per-channel generation count (GEN_W bits per channel)
//   err_timeout      per-channel sticky timeout flag
//   err_stray        per-channel sticky stray-arrival flag
//   err_clr          clears all sticky error flags
module barrier_sync_unit
  import barrier_sync_unit_pkg::*;
#(
  parameter int unsigned NUM_PE  = DEF_NUM_PE,
  parameter int unsigned NUM_BAR = DEF_NUM_BAR,
  parameter int unsigned BID_W   = bid_width(NUM_BAR),
  parameter int unsigned GEN_W   = DEF_GEN_W,
  parameter int unsigned TO_W    = DEF_TO_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [BID_W-1:0]         cfg_bar_id,
  input  logic [NUM_PE-1:0]        cfg_mask,
  input  logic                     cfg_persistent,
  input  logic [TO_W-1:0]          cfg_timeout,
  input  logic [NUM_PE-1:0]        pe_arrive,
  input  logic [NUM_PE*BID_W-1:0]  pe_bar_id,
  output logic [NUM_PE-1:0]        pe_release,
  output logic [NUM_BAR-1:0]       bar_active,
  output logic [NUM_BAR*GEN_W-1:0] bar_gen,
  output logic [NUM_BAR-1:0]       err_timeout,
  output logic [NUM_BAR-1:0]       err_stray,
  input  logic                     err_clr
);

  logic [NUM_BAR-1:0]      idle;
  logic [(1<<BID_W)-1:0]   idle_ext;
  logic [NUM_BAR-1:0]      cfg_accept;
  logic [NUM_PE-1:0]       arr    [NUM_BAR];
  logic [NUM_PE-1:0]       rel    [NUM_BAR];
  logic [GEN_W-1:0]        gen    [NUM_BAR];

  // Ids beyond NUM_BAR read as never-ready.
  always_comb begin
    idle_ext              = '0;
    idle_ext[NUM_BAR-1:0] = idle;
    cfg_ready             = idle_ext[cfg_bar_id];
  end

  always_comb begin
    for (int unsigned b = 0; b < NUM_BAR; b++) begin
      cfg_accept[b] = cfg_valid && cfg_ready && (cfg_bar_id == BID_W'(b));
      arr[b]        = '0;
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        arr[b][i] = pe_arrive[i] && (pe_bar_id[i*BID_W +: BID_W] == BID_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BAR; b++) begin : g_ch
    barrier_channel #(
      .NUM_PE (NUM_PE),
      .GEN_W  (GEN_W),
      .TO_W   (TO_W)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .cfg_accept     (cfg_accept[b]),
      .cfg_mask       (cfg_mask),
      .cfg_persistent (cfg_persistent),
      .cfg_timeout    (cfg_timeout),
      .arrive         (arr[b]),
      .err_clr        (err_clr),
      .idle           (idle[b]),
      .release_vec    (rel[b]),
      .gen            (gen[b]),
      .err_timeout    (err_timeout[b]),
      .err_stray      (err_stray[b])
    );
    assign bar_gen[b*GEN_W +: GEN_W] = gen[b];
  end

  assign bar_active = ~idle;

  always_comb begin
    pe_release = '0;
    for (int unsigned b = 0; b < NUM_BAR; b++) begin
      pe_release = pe_release | rel[b];
    end
  end

endmodule

// File: tb/tb_barrier_sync_unit.sv
module tb_barrier_sync_unit;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_bar_id;
  logic [15:0] cfg_mask;
  logic        cfg_persistent;
  logic [15:0] cfg_timeout;
  logic [15:0] pe_arrive;
  logic [31:0] pe_bar_id;
  logic [15:0] pe_release;
  logic [3:0]  bar_active;
  logic [15:0] bar_gen;
  logic [3:0]  err_timeout;
  logic [3:0]  err_stray;
  logic        err_clr;

  barrier_sync_unit #(
    .NUM_PE  (16),
    .NUM_BAR (4),
    .BID_W   (2),
    .GEN_W   (4),
    .TO_W    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_bar_id     (cfg_bar_id),
    .cfg_mask       (cfg_mask),
    .cfg_persistent (cfg_persistent),
    .cfg_timeout    (cfg_timeout),
    .pe_arrive      (pe_arrive),
    .pe_bar_id      (pe_bar_id),
    .pe_release     (pe_release),
    .bar_active     (bar_active),
    .bar_gen        (bar_gen),
    .err_timeout    (err_timeout),
    .err_stray      (err_stray),
    .err_clr        (err_clr)
  );

  typedef struct {
    int          cyc;
    logic [15:0] mask;
  } rel_t;

  rel_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  logic [15:0] rel_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Release scoreboard: every cycle pe_release must equal the queued
  // expectation for that cycle, or zero when none is queued.
  always @(negedge clk) begin
    if (mon_en) begin
      rel_exp = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        rel_exp = sb[0].mask;
        void'(sb.pop_front());
      end
      checks++;
      assert (pe_release === rel_exp) else begin
        errors++;
        $error("FAIL release cyc=%0d observed=%h expected=%h", cyc, pe_release, rel_exp);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_rel(input logic [15:0] m);
    rel_t e;
    e.cyc  = cyc + 1;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic add(input logic [15:0] m, input int id);
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        pe_arrive[i]       = 1'b1;
        pe_bar_id[i*2 +: 2] = 2'(id);
      end
    end
  endtask

  task automatic fire();
    tick(1);
    pe_arrive = '0;
  endtask

  task automatic do_cfg(input int id, input logic [15:0] m, input logic p, input logic [15:0] t);
    cfg_valid      = 1'b1;
    cfg_bar_id     = 2'(id);
    cfg_mask       = m;
    cfg_persistent = p;
    cfg_timeout    = t;
    #1;
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    tick(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; cfg_valid = 1'b0; cfg_bar_id = '0; cfg_mask = '0;
    cfg_persistent = 1'b0; cfg_timeout = '0; pe_arrive = '0; pe_bar_id = '0;
    err_clr = 1'b0;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    mon_en = 1;
    tick(1);

    // Reset state
    chk("rst_active", {28'd0, bar_active}, 32'd0);
    chk("rst_gen", {16'd0, bar_gen}, 32'd0);
    chk("rst_errs", {24'd0, err_timeout, err_stray}, 32'd0);
    #1 chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

    // Basic one-shot on ch0
    do_cfg(0, 16'h000F, 1'b0, 16'd0);
    chk("t1_active", {28'd0, bar_active}, 32'h1);
    chk("t1_ready_armed", {31'd0, cfg_ready}, 32'd0);
    tick(2);
    add(16'h0001, 0); fire();
    tick(1);
    add(16'h0006, 0); fire();
    tick(2);
    exp_rel(16'h000F);
    add(16'h0008, 0); fire();
    chk("t1_gen", {16'd0, bar_gen}, 32'h0001);
    chk("t1_idle", {28'd0, bar_active}, 32'h0);
    chk("t1_ready_after", {31'd0, cfg_ready}, 32'd1);
    tick(2);

    // Cyclic on ch1
    do_cfg(1, 16'h0003, 1'b1, 16'd0);
    tick(2);
    exp_rel(16'h0003);
    add(16'h0003, 1); fire();
    add(16'h0001, 1); fire();
    chk("t2_gen1", {16'd0, bar_gen}, 32'h0011);
    tick(2);
    exp_rel(16'h0003);
    add(16'h0002, 1); fire();
    chk("t2_gen2", {16'd0, bar_gen}, 32'h0021);
    chk("t2_armed", {28'd0, bar_active}, 32'h2);

    // Stray and duplicate on ch0, stray to idle ch3, clear priority
    do_cfg(0, 16'h000F, 1'b0, 16'd0);
    add(16'h0002, 0); fire();
    add(16'h0002, 0); fire();
    chk("t3_dup_noerr", {28'd0, err_stray}, 32'h0);
    add(16'h0100, 0); fire();
    chk("t3_stray_mask", {28'd0, err_stray}, 32'h1);
    add(16'h1000, 3); fire();
    chk("t3_stray_idle", {28'd0, err_stray}, 32'h9);
    err_clr = 1'b1;
    add(16'h1000, 3); fire();
    err_clr = 1'b0;
    chk("t3_clr_priority", {28'd0, err_stray}, 32'h8);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t3_clr", {28'd0, err_stray}, 32'h0);
    exp_rel(16'h000F);
    add(16'h000D, 0); fire();
    chk("t3_gen", {16'd0, bar_gen}, 32'h0022);

    // Timeout on ch2 (limit 20, PE7 never arrives)
    do_cfg(2, 16'h00F0, 1'b0, 16'd20);
    add(16'h0070, 2); fire();
    tick(16);
    chk("t4_before_to", {27'd0, bar_active[2], err_timeout}, 32'h10);
    tick(5);
    chk("t4_to_flag", {28'd0, err_timeout}, 32'h4);
    chk("t4_to_idle", {31'd0, bar_active[2]}, 32'd0);
    chk("t4_to_gen", {16'd0, bar_gen}, 32'h0022);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t4_clr", {28'd0, err_timeout}, 32'h0);

    // Zero mask: handshake completes, channel stays idle
    do_cfg(2, 16'h0000, 1'b0, 16'd0);
    chk("zero_mask_idle", {31'd0, bar_active[2]}, 32'd0);

    // Concurrent completion, held config until release
    do_cfg(0, 16'h0001, 1'b0, 16'd0);
    do_cfg(3, 16'h0100, 1'b0, 16'd0);
    cfg_valid = 1'b1; cfg_bar_id = 2'd0; cfg_mask = 16'h0002;
    cfg_persistent = 1'b0; cfg_timeout = '0;
    #1 chk("t5_ready_held", {31'd0, cfg_ready}, 32'd0);
    tick(1);
    chk("t5_ready_held2", {31'd0, cfg_ready}, 32'd0);
    exp_rel(16'h0101);
    add(16'h0001, 0); add(16'h0100, 3); fire();
    chk("t5_ready_rel", {31'd0, cfg_ready}, 32'd1);
    tick(1);
    cfg_valid = 1'b0;
    chk("t5_rearmed", {28'd0, bar_active}, 32'h3);
    exp_rel(16'h0002);
    add(16'h0002, 0); fire();
    chk("t5_gens", {16'd0, bar_gen}, 32'h1024);

    // Reset mid-barrier
    do_cfg(0, 16'h000F, 1'b0, 16'd0);
    add(16'h0003, 0); fire();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", {pe_release, bar_gen}, 32'h0);
    chk("t6_rst_flags", {20'd0, bar_active, err_timeout, err_stray}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    add(16'h000C, 0); fire();
    tick(3);
    chk("t6_gen", {16'd0, bar_gen}, 32'h0);
    chk("t6_idle_stray", {24'd0, bar_active, err_stray}, 32'h01);

    tick(2);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
